// File: rtl/mtimer_pkg.sv
// ----------------------------------------------------------------------------
// mtimer_pkg : register offsets, CTRL fields, bus FSM encoding, strobe helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mtimer_pkg;

  localparam logic [2:0] MTMR_CTRL    = 3'd0;
  localparam logic [2:0] MTMR_STATUS  = 3'd1;
  localparam logic [2:0] MTMR_TIME_LO = 3'd2;
  localparam logic [2:0] MTMR_TIME_HI = 3'd3;
  localparam logic [2:0] MTMR_CMP_LO  = 3'd4;
  localparam logic [2:0] MTMR_CMP_HI  = 3'd5;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int CTRL_DIV_LSB   = 8;
  localparam int CTRL_DIV_W     = 8;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_WR   = 2'd1,
    BUS_RD   = 2'd2,
    BUS_RDAT = 2'd3
  } bus_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mtimer_if.sv
// ----------------------------------------------------------------------------
// mtimer_if : slave-side AXI4-lite subset (no B channel, prot or resp)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mtimer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [AW-1:0]   araddr;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
    input  awready, wready, arready, rdata, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, araddr, arvalid, rready,
    output awready, wready, arready, rdata, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/mtimer_axil_slv_if.sv
// ----------------------------------------------------------------------------
// axil_slv_if : IDLE/WR/RD/RDAT handshake FSM exposing a simple register port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axil_slv_if
  import mtimer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  mtimer_if.slave         s_axi,
  output logic            reg_we_o,
  output logic            reg_re_o,
  output logic [2:0]      reg_addr_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic [DW/8-1:0] reg_wstrb_o,
  input  logic [DW-1:0]   reg_rdata_i
);

  bus_state_e      state_q;
  logic            awready_q;
  logic            wready_q;
  logic            arready_q;
  logic            rvalid_q;
  logic [DW-1:0]   rdata_q;
  logic            we_q;
  logic            re_q;
  logic [2:0]      addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi.awaddr[AW-1:5], s_axi.awaddr[1:0],
                              s_axi.araddr[AW-1:5], s_axi.araddr[1:0]};

  // Address and write data are captured on leaving IDLE; the master holds
  // them stable until the ready pulse, so the captured copy is exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BUS_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      case (state_q)
        BUS_IDLE: begin
          if (s_axi.awvalid && s_axi.wvalid) begin
            state_q   <= BUS_WR;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            we_q      <= 1'b1;
            addr_q    <= s_axi.awaddr[4:2];
            wdata_q   <= s_axi.wdata;
            wstrb_q   <= s_axi.wstrb;
          end else if (s_axi.arvalid) begin
            state_q   <= BUS_RD;
            arready_q <= 1'b1;
            re_q      <= 1'b1;
            addr_q    <= s_axi.araddr[4:2];
          end
        end
        BUS_WR: state_q <= BUS_IDLE;
        BUS_RD: begin
          state_q  <= BUS_RDAT;
          rvalid_q <= 1'b1;
          rdata_q  <= reg_rdata_i;
        end
        BUS_RDAT: begin
          if (s_axi.rready) begin
            state_q  <= BUS_IDLE;
            rvalid_q <= 1'b0;
          end
        end
        default: state_q <= BUS_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign reg_we_o      = we_q;
  assign reg_re_o      = re_q;
  assign reg_addr_o    = addr_q;
  assign reg_wdata_o   = wdata_q;
  assign reg_wstrb_o   = wstrb_q;

endmodule

`default_nettype wire

// File: rtl/mtimer.sv
// ----------------------------------------------------------------------------
// mtimer : 64-bit machine timer with prescaler, compare and level interrupt
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mtimer
  import mtimer_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic    clk,
  input  logic    rst,
  mtimer_if.slave tmr_axi,
  output logic    timer_irq_o
);

  logic            reg_we;
  logic            reg_re;
  logic [2:0]      reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [DW/8-1:0] reg_wstrb;
  logic [DW-1:0]   reg_rdata;

  axil_slv_if #(.AW(AW), .DW(DW)) u_bus (
    .clk         (clk),
    .rst         (rst),
    .s_axi       (tmr_axi),
    .reg_we_o    (reg_we),
    .reg_re_o    (reg_re),
    .reg_addr_o  (reg_addr),
    .reg_wdata_o (reg_wdata),
    .reg_wstrb_o (reg_wstrb),
    .reg_rdata_i (reg_rdata)
  );

  logic                  en_q, en_d;
  logic                  irq_en_q, irq_en_d;
  logic [CTRL_DIV_W-1:0] div_q, div_d;
  logic [CTRL_DIV_W-1:0] prs_q, prs_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           cmp_q, cmp_d;
  logic [31:0]           shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  irq_q, irq_d;
  logic                  tick, cmp_hit;
  logic                  wr_ctrl, wr_status, wr_tlo, wr_thi, wr_clo, wr_chi;

  assign wr_ctrl   = reg_we && (reg_addr == MTMR_CTRL);
  assign wr_status = reg_we && (reg_addr == MTMR_STATUS);
  assign wr_tlo    = reg_we && (reg_addr == MTMR_TIME_LO);
  assign wr_thi    = reg_we && (reg_addr == MTMR_TIME_HI);
  assign wr_clo    = reg_we && (reg_addr == MTMR_CMP_LO);
  assign wr_chi    = reg_we && (reg_addr == MTMR_CMP_HI);

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    if (wr_ctrl && reg_wstrb[0]) begin
      en_d     = reg_wdata[CTRL_EN_BIT];
      irq_en_d = reg_wdata[CTRL_IRQEN_BIT];
    end
    if (wr_ctrl && reg_wstrb[1]) div_d = reg_wdata[CTRL_DIV_LSB +: CTRL_DIV_W];

    tick = en_q && (prs_q == div_q);
    if (!en_q || wr_ctrl || tick) prs_d = '0;
    else                          prs_d = prs_q + 1'b1;

    // A bus write to either half of mtime replaces that cycle's increment.
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_tlo) mtime_d = {mtime_q[63:32], apply_strb(mtime_q[31:0], reg_wdata, reg_wstrb)};
    if (wr_thi) mtime_d = {apply_strb(mtime_q[63:32], reg_wdata, reg_wstrb), mtime_q[31:0]};

    cmp_d = cmp_q;
    if (wr_clo) cmp_d[31:0]  = apply_strb(cmp_q[31:0], reg_wdata, reg_wstrb);
    if (wr_chi) cmp_d[63:32] = apply_strb(cmp_q[63:32], reg_wdata, reg_wstrb);

    cmp_hit = en_q && (mtime_q >= cmp_q);
    if (cmp_hit)                                      pending_d = 1'b1;
    else if (wr_status && reg_wstrb[0] && reg_wdata[0]) pending_d = 1'b0;
    else                                              pending_d = pending_q;

    shadow_d = (reg_re && (reg_addr == MTMR_TIME_LO)) ? mtime_q[63:32] : shadow_q;
    irq_d    = pending_q && irq_en_q;

    reg_rdata = '0;
    case (reg_addr)
      MTMR_CTRL: begin
        reg_rdata[CTRL_EN_BIT]                   = en_q;
        reg_rdata[CTRL_IRQEN_BIT]                = irq_en_q;
        reg_rdata[CTRL_DIV_LSB +: CTRL_DIV_W]    = div_q;
      end
      MTMR_STATUS:  reg_rdata[0] = pending_q;
      MTMR_TIME_LO: reg_rdata    = mtime_q[31:0];
      MTMR_TIME_HI: reg_rdata    = shadow_q;
      MTMR_CMP_LO:  reg_rdata    = cmp_q[31:0];
      MTMR_CMP_HI:  reg_rdata    = cmp_q[63:32];
      default:      reg_rdata    = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
      div_q     <= '0;
      prs_q     <= '0;
      mtime_q   <= '0;
      cmp_q     <= '1;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      en_q      <= en_d;
      irq_en_q  <= irq_en_d;
      div_q     <= div_d;
      prs_q     <= prs_d;
      mtime_q   <= mtime_d;
      cmp_q     <= cmp_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign timer_irq_o = irq_q;

endmodule

`default_nettype wire

// File: doc/mtimer.md
Name: mtimer

Overview:
- Machine-timer peripheral attached as slave s3 of the 2-master/16-slave AXI4-lite interconnect.
- It holds a 64-bit free-running time counter with a programmable prescaler and a 64-bit compare register.
- It raises a level interrupt toward the core when the time counter reaches the compare value.
- Its bus interface uses the slave-side AXI4-lite subset of the interconnect: no B channel, no prot, no resp signals.

Parameters:
- AW, 32, address width; matches the interconnect slave address bus.
- DW, 32, data width; fixed at 32, wstrb is DW/8.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- tmr_axi_awaddr  in  AW  write address; only bits [4:2] are decoded
- tmr_axi_awvalid  in  1  write address valid
- tmr_axi_awready  out  1  write address accept
- tmr_axi_wdata  in  DW  write data
- tmr_axi_wstrb  in  4  byte strobes
- tmr_axi_wvalid  in  1  write data valid
- tmr_axi_wready  out  1  write data accept
- tmr_axi_araddr  in  AW  read address
- tmr_axi_arvalid  in  1  read address valid
- tmr_axi_arready  out  1  read address accept
- tmr_axi_rdata  out  DW  read data
- tmr_axi_rvalid  out  1  read data valid
- tmr_axi_rready  in  1  read data accept
- timer_irq_o  out  1  timer interrupt, level

Behaviour:
- Reset, asynchronous: every register is 0 except CMP, which resets to 64'hFFFF_FFFF_FFFF_FFFF. All ready/valid outputs, rdata and timer_irq_o reset to 0. The bus FSM resets to IDLE. Reset mid-transaction aborts it with no register side effects.
- Register map, offset = addr[4:2]*4:
  - 0x00 CTRL: [0] en, [1] irq_en, [15:8] div; other bits read 0.
  - 0x04 STATUS: [0] pending; write-1-to-clear.
  - 0x08 MTIME_LO.
  - 0x0C MTIME_HI.
  - 0x10 CMP_LO.
  - 0x14 CMP_HI.
  - 0x18 and 0x1C: reads return 0, writes are ignored.
- Byte strobes apply to every writable byte. STATUS honours only strobe [0].
- Bus FSM states: IDLE, WR, RD, RDAT.
  - IDLE→WR when awvalid&&wvalid; write has priority over a simultaneous arvalid.
  - IDLE→RD when arvalid and no write is ready.
  - WR: awready=wready=1 for exactly one cycle. The register update takes effect at the closing edge. Then →IDLE.
  - RD: arready=1 for one cycle; araddr is latched. →RDAT.
  - RDAT: rvalid=1 and rdata is held stable until rready. →IDLE on the rvalid&&rready edge.
  - A read occupies a minimum of 3 cycles, arvalid to rvalid+rready. A write occupies 1 cycle after IDLE.
  - No new address is accepted outside IDLE.
- Prescaler:
  - 8-bit counter prs; when en=0 it is held at 0.
  - When en=1: if prs==div, then tick=1 and prs←0; otherwise prs←prs+1.
  - div=0 gives a tick every cycle; div=N gives a tick every N+1 cycles.
  - A write to CTRL clears prs.
- Time counter:
  - mtime←mtime+1 on each tick; wraps from 2^64-1 to 0 with no flag.
  - A bus write to MTIME_LO/HI in the same cycle as a tick: the written bytes take the written value, and the increment is dropped that cycle.
- Read coherency: reading MTIME_LO snapshots mtime[63:32] into a shadow register. Reading MTIME_HI returns the shadow, not the live value.
- Compare: unsigned. When en=1 and mtime>=CMP, pending←1 every cycle.
- Pending clear: a W1C to pending in the same cycle as a true compare leaves pending=1, because set wins.
- Interrupt: timer_irq_o = pending && irq_en, registered, one cycle after pending. Writing irq_en=0 drops it the cycle after the write.
- en=0 freezes mtime and suppresses new pending sets; an existing pending is kept.

Decomposition:
- Shared package/defines header gets:
  - register offsets (MTMR_CTRL, MTMR_STATUS, MTMR_TIME_LO/HI, MTMR_CMP_LO/HI);
  - CTRL bit positions;
  - the bus FSM state encoding, reused by future s4+ slaves.
- One natural sub-module: axil_slv_if. It implements the IDLE/WR/RD/RDAT handshake FSM and presents a simple reg_we/reg_addr/reg_wdata/reg_wstrb/reg_re/reg_rdata port.
- mtimer instantiates axil_slv_if plus the counter, compare and register logic.

Test Plan:
- Reset check: after reset, read CMP_LO→0xFFFFFFFF, MTIME_LO→0, CTRL→0; timer_irq_o=0 throughout.
- Basic match: write CMP_LO=20, CMP_HI=0, CTRL=0x3 (div=0). timer_irq_o rises within 22 cycles of the CTRL write. W1C STATUS while mtime>=CMP → pending reads 1 again. Writing CMP_LO=0xFFFFFFFF, CMP_HI=0xFFFFFFFF then W1C → irq drops the cycle after the clear.
- Prescaler: CTRL=0x0401 (div=4). After 50 cycles, MTIME_LO equals 10±1. A CTRL rewrite restarts prs.
- Wrap: write MTIME_LO=0xFFFFFFFE, MTIME_HI=0xFFFFFFFF with en=1, div=0. MTIME_LO then MTIME_HI read back a wrapped small value with HI=0, consistent via the shadow.
- Handshake: hold rready low for 5 cycles in RDAT → rvalid and rdata stay stable. Simultaneous awvalid+wvalid+arvalid in IDLE → write is served first, read follows. Byte write wstrb=4'b0010, wdata=0x0000AB00 to CMP_LO → only byte 1 changes.
- Async reset mid-read: assert rst during RDAT → rvalid goes 0 immediately, and the FSM is in IDLE after release.
